riscq_boot_loader: RTL
======================

// Module: riscq_boot_loader
// PURPOSE
//  Boot sequencer in front of riscq_soc. Accepts load commands and a word stream from a host,
//  writes instruction ROM and data RAM through the soc init ports, then asserts both
//  init_done flags and releases the CPU reset after a programmable delay.
//  Replaces hand-sequenced ROM/RAM init and reset release. Sits between host link and riscq_soc.
// PARAMETERS
//  ADDR_W      12    word address width of the inst/data init ports
//  DATA_W      32    word width
//  DEPTH       1024  words per memory; base+len > DEPTH is an error
//  RELEASE_DLY 2     cycles from init_done rise to CPU reset release (>=1)
// PORTS
//  i_clk            in   1        clock
//  i_rst_n          in   1        asynchronous active-low reset
//  i_cmd_valid      in   1        load command valid
//  o_cmd_ready      out  1        command accepted when valid&ready
//  i_cmd_sel        in   1        0 = inst ROM, 1 = data RAM
//  i_cmd_base       in   ADDR_W   first word address
//  i_cmd_len        in   ADDR_W+1 word count (0 = no-op)
//  i_wr_valid       in   1        stream word valid
//  o_wr_ready       out  1        stream word accepted when valid&ready
//  i_wr_data        in   DATA_W   stream word
//  i_start          in   1        pulse: finish init, boot CPU
//  i_stop           in   1        pulse: halt CPU, return to IDLE
//  i_clr_err        in   1        pulse: leave ERR
//  o_inst_waddr/o_inst_wdata/o_inst_we  out ADDR_W/DATA_W/1  to soc i_inst_*
//  o_data_waddr/o_data_wdata/o_data_we  out ADDR_W/DATA_W/1  to soc i_data_*
//  o_inst_init_done out  1        to soc i_inst_init_done
//  o_data_init_done out  1        to soc i_data_init_done
//  o_cpu_rst        out  1        active-high reset to soc i_rst
//  o_state          out  3        IDLE=0 LOAD=1 ARM=2 RUN=3 ERR=4
//  o_err_code       out  2        0 none, 1 range, 2 checksum
// BEHAVIOUR
//  - Reset: state IDLE; o_cpu_rst=1; all other outputs 0. Async assert, sync deassert of internal state.
//  - o_cmd_ready = (state==IDLE); o_wr_ready = (state==LOAD). Combinational from state only.
//  - IDLE: cmd handshake latches sel/base/len, clears word counter.
//      len==0 -> stay IDLE; base+len > DEPTH -> ERR, code 1; else -> LOAD.
//      i_start (no cmd handshake same cycle) -> ARM; cmd handshake wins over simultaneous i_start.
//  - LOAD: each wr handshake at cycle N drives, at N+1, selected we=1, waddr=base+cnt, wdata=word;
//      the other memory's we stays 0. After handshake with cnt==len-1 -> IDLE. Gaps in i_wr_valid allowed.
//  - ARM: o_inst_init_done=o_data_init_done=1 from first ARM cycle; o_cpu_rst stays 1 for
//      RELEASE_DLY cycles, then -> RUN with o_cpu_rst=0.
//  - RUN: init_done held 1, o_cpu_rst=0. i_stop -> IDLE next cycle: o_cpu_rst=1, init_done=0.
//  - ERR: o_cpu_rst=1, init_done=0, no writes; i_clr_err -> IDLE, o_err_code=0.
//  - i_start/i_stop/i_clr_err ignored outside the states listed. No write ever coincides with init_done=1.
//  - Address arithmetic in ADDR_W+1 bits; no wrap (range check rejects it up front).
//  - Async reset mid-LOAD/ARM/RUN: immediate return to reset values; partial load is not resumed.
// CONFIGURATION
//  RISCQ_BOOT_CHECKSUM_EN defined: adds i_exp_sum[DATA_W] and o_sum[DATA_W]; o_sum = mod-2^DATA_W
//    sum of all words accepted since reset or since leaving ERR/RUN to IDLE; i_start in IDLE with
//    o_sum != i_exp_sum -> ERR, code 2 (CPU never released).
//  Not defined: ports absent, no check, code 2 never produced.
// TESTING
//  1 Reset: i_rst_n=0 -> o_cpu_rst=1, o_state=0, all we/init_done=0, cmd_ready=1.
//  2 cmd(sel=0,base=0,len=4), words 0x11..0x14 with one idle gap -> 4 inst writes addr 0..3, each 1 cycle after handshake; data_we never 1.
//  3 cmd(sel=1,base=1020,len=5) -> ERR, o_err_code=1, no writes; i_clr_err -> IDLE.
//  4 i_start in IDLE -> init_done=1 next cycle, o_cpu_rst falls exactly RELEASE_DLY=2 cycles later; i_stop -> cpu_rst=1, init_done=0.
//  5 i_start and cmd_valid same cycle in IDLE -> LOAD, start ignored.
//  6 CHECKSUM_EN: load 1,2,3 then i_exp_sum=7, i_start -> ERR code 2; with i_exp_sum=6 -> RUN.

Source files
------------

// File: rtl/riscq_boot_loader_if.sv
// riscq_boot_loader_if: host command/stream and soc init bus of the boot loader; checksum ports under RISCQ_BOOT_CHECKSUM_EN
interface riscq_boot_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_sel;
  logic [ADDR_W-1:0] i_cmd_base;
  logic [ADDR_W:0]   i_cmd_len;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_start;
  logic              i_stop;
  logic              i_clr_err;
  logic [ADDR_W-1:0] o_inst_waddr;
  logic [DATA_W-1:0] o_inst_wdata;
  logic              o_inst_we;
  logic [ADDR_W-1:0] o_data_waddr;
  logic [DATA_W-1:0] o_data_wdata;
  logic              o_data_we;
  logic              o_inst_init_done;
  logic              o_data_init_done;
  logic              o_cpu_rst;
  logic [2:0]        o_state;
  logic [1:0]        o_err_code;
`ifdef RISCQ_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] i_exp_sum;
  logic [DATA_W-1:0] o_sum;
`endif
  modport slave (
`ifdef RISCQ_BOOT_CHECKSUM_EN
    input  i_exp_sum,
    output o_sum,
`endif
    input  i_cmd_valid, i_cmd_sel, i_cmd_base, i_cmd_len, i_wr_valid, i_wr_data,
    input  i_start, i_stop, i_clr_err,
    output o_cmd_ready, o_wr_ready, o_inst_waddr, o_inst_wdata, o_inst_we,
    output o_data_waddr, o_data_wdata, o_data_we, o_inst_init_done, o_data_init_done,
    output o_cpu_rst, o_state, o_err_code
  );
  modport master (
`ifdef RISCQ_BOOT_CHECKSUM_EN
    output i_exp_sum,
    input  o_sum,
`endif
    output i_cmd_valid, i_cmd_sel, i_cmd_base, i_cmd_len, i_wr_valid, i_wr_data,
    output i_start, i_stop, i_clr_err,
    input  o_cmd_ready, o_wr_ready, o_inst_waddr, o_inst_wdata, o_inst_we,
    input  o_data_waddr, o_data_wdata, o_data_we, o_inst_init_done, o_data_init_done,
    input  o_cpu_rst, o_state, o_err_code
  );
endinterface

// File: rtl/riscq_boot_loader.sv
// riscq_boot_loader: loads soc inst ROM / data RAM from a host stream, then boots the CPU; RISCQ_BOOT_CHECKSUM_EN adds a load checksum gate on start
module riscq_boot_loader #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int RELEASE_DLY = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  riscq_boot_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, ARM = 3'd2, RUN = 3'd3, ERR = 3'd4} state_t;
  localparam int DW = RELEASE_DLY > 1 ? $clog2(RELEASE_DLY) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(RELEASE_DLY - 1);
  localparam logic [DW-1:0] DLY_ONE = DW'(1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W + 2)'(DEPTH);
  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d, cnt_nxt;
  logic [DW-1:0]     dly_q, dly_d;
  logic              inst_we_q, inst_we_d, data_we_q, data_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d, cpu_rst_q, cpu_rst_d;
  logic [1:0]        err_q, err_d;
  logic              range_bad, sum_bad;
  assign cnt_nxt   = cnt_q + CNT_ONE;
  assign range_bad = ({2'b00, bus.i_cmd_base} + {1'b0, bus.i_cmd_len}) > DEPTH_W;
  assign bus.o_cmd_ready      = state_q == IDLE;
  assign bus.o_wr_ready       = state_q == LOAD;
  assign bus.o_inst_waddr     = waddr_q;
  assign bus.o_inst_wdata     = wdata_q;
  assign bus.o_inst_we        = inst_we_q;
  assign bus.o_data_waddr     = waddr_q;
  assign bus.o_data_wdata     = wdata_q;
  assign bus.o_data_we        = data_we_q;
  assign bus.o_inst_init_done = done_q;
  assign bus.o_data_init_done = done_q;
  assign bus.o_cpu_rst        = cpu_rst_q;
  assign bus.o_state          = state_q;
  assign bus.o_err_code       = err_q;
`ifdef RISCQ_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              sum_clr;
  assign sum_clr   = (state_q == RUN && bus.i_stop) || (state_q == ERR && bus.i_clr_err);
  assign sum_bad   = sum_q != bus.i_exp_sum;
  assign bus.o_sum = sum_q;
  // Running sum of accepted stream words, restarted whenever the loader falls back to IDLE from RUN/ERR
  always_comb sum_d = sum_clr ? '0 : (state_q == LOAD && bus.i_wr_valid) ? sum_q + bus.i_wr_data : sum_q;
  // Checksum register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) sum_q <= '0;
    else sum_q <= sum_d;
`else
  assign sum_bad = 1'b0;
`endif
  // Next-state and registered-output logic of the boot sequencer
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    inst_we_d = 1'b0;
    data_we_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    cpu_rst_d = cpu_rst_q;
    err_d     = err_q;
    case (state_q)
      IDLE:
        if (bus.i_cmd_valid) begin
          sel_d   = bus.i_cmd_sel;
          base_d  = bus.i_cmd_base;
          len_d   = bus.i_cmd_len;
          cnt_d   = '0;
          state_d = bus.i_cmd_len == '0 ? IDLE : range_bad ? ERR : LOAD;
          err_d   = bus.i_cmd_len != '0 && range_bad ? 2'd1 : err_q;
        end else if (bus.i_start) begin
          state_d = sum_bad ? ERR : ARM;
          err_d   = sum_bad ? 2'd2 : err_q;
          done_d  = !sum_bad;
          dly_d   = '0;
        end
      LOAD:
        if (bus.i_wr_valid) begin
          inst_we_d = !sel_q;
          data_we_d = sel_q;
          waddr_d   = base_q + cnt_q[ADDR_W-1:0];
          wdata_d   = bus.i_wr_data;
          cnt_d     = cnt_nxt;
          state_d   = cnt_nxt == len_q ? IDLE : LOAD;
        end
      ARM: begin
        state_d   = dly_q == DLY_LAST ? RUN : ARM;
        cpu_rst_d = dly_q != DLY_LAST;
        dly_d     = dly_q + DLY_ONE;
      end
      RUN:
        if (bus.i_stop) begin
          state_d   = IDLE;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
        end
      ERR:
        if (bus.i_clr_err) begin
          state_d = IDLE;
          err_d   = 2'd0;
        end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; async reset returns everything to the pre-boot values
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      dly_q     <= '0;
      inst_we_q <= 1'b0;
      data_we_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      err_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      inst_we_q <= inst_we_d;
      data_we_q <= data_we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
      err_q     <= err_d;
    end
endmodule
